// File: rtl/clock_pkg.sv
// Shared mode encoding, field limits and small helpers for the time-set clock.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } mode_e;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] HOUR_MAX = 6'd23;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_RUN:      return MODE_SET_HOUR;
      MODE_SET_HOUR: return MODE_SET_MIN;
      MODE_SET_MIN:  return MODE_SET_SEC;
      default:       return MODE_RUN;
    endcase
  endfunction

  // Only the field being edited blinks; bit0 sec, bit1 min, bit2 hour.
  function automatic logic [2:0] blank_mask(input mode_e m, input logic phase);
    case (m)
      MODE_SET_HOUR: return {phase, 2'b00};
      MODE_SET_MIN:  return {1'b0, phase, 1'b0};
      MODE_SET_SEC:  return {2'b00, phase};
      default:       return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer plus registered rising-edge detector for one raw button.
module btn_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic evt_o
);

  logic       sync1_q, sync2_q, prev_q, evt_q, armed_q;
  logic [1:0] vld_q;

  // armed_q only sets once a genuine low has been seen after reset, so a
  // button held through reset release never produces an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      evt_q   <= 1'b0;
      armed_q <= 1'b0;
      vld_q   <= 2'b00;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_q | (vld_q[1] & ~sync2_q);
      evt_q   <= sync2_q & ~prev_q & armed_q;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/time_set_controller.sv
// HH:MM:SS clock with a run mode and a three-field blinking set mode.
module time_set_controller
  import clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 1000,
  parameter int unsigned BLINK_HALF    = 500
) (
  input  logic       clk_1000hz,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [5:0] hour,
  output logic [1:0] mode,
  output logic [2:0] blank,
  output logic       tick_1hz
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [PW-1:0] PRESC_TERM = PW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BLINK_TERM = BW'(BLINK_HALF - 1);
  localparam int BTN_MODE = 0;
  localparam int BTN_INC  = 1;

  logic [1:0] btn_raw, btn_evt;
  assign btn_raw = {btn_inc, btn_mode};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    btn_edge u_btn (
      .clk_i (clk_1000hz),
      .rst_i (rst),
      .btn_i (btn_raw[i]),
      .evt_o (btn_evt[i])
    );
  end

  mode_e          mode_q, mode_d;
  logic [5:0]     sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [BW-1:0]  bcnt_q, bcnt_d;
  logic           blink_q, blink_d;
  logic           tick_q, tick_d;
  logic [2:0]     blank_q, blank_d;
  logic           inc_ok;

  always_comb begin
    mode_d  = mode_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    presc_d = presc_q;
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    tick_d  = 1'b0;
    inc_ok  = btn_evt[BTN_INC] & ~btn_evt[BTN_MODE] & (mode_q != MODE_RUN);

    if (mode_q == MODE_RUN) begin
      bcnt_d  = '0;
      blink_d = 1'b0;
      if (presc_q == PRESC_TERM) begin
        presc_d = '0;
        tick_d  = 1'b1;
        sec_d   = wrap_inc(sec_q, SEC_MAX);
        if (sec_q == SEC_MAX) begin
          min_d = wrap_inc(min_q, MIN_MAX);
          if (min_q == MIN_MAX) hour_d = wrap_inc(hour_q, HOUR_MAX);
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else begin
      presc_d = '0;
      if (bcnt_q == BLINK_TERM) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d  = bcnt_q + 1'b1;
      end
    end

    // Field edits never carry into neighbouring fields.
    if (inc_ok) begin
      bcnt_d  = '0;
      blink_d = 1'b0;
      case (mode_q)
        MODE_SET_HOUR: hour_d = wrap_inc(hour_q, HOUR_MAX);
        MODE_SET_MIN:  min_d  = wrap_inc(min_q, MIN_MAX);
        MODE_SET_SEC:  sec_d  = wrap_inc(sec_q, SEC_MAX);
        default:       ;
      endcase
    end

    if (btn_evt[BTN_MODE]) begin
      mode_d  = next_mode(mode_q);
      presc_d = '0;
      bcnt_d  = '0;
      blink_d = 1'b0;
    end

    blank_d = blank_mask(mode_d, blink_d);
  end

  always_ff @(posedge clk_1000hz) begin
    if (rst) begin
      mode_q  <= MODE_RUN;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      presc_q <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
      tick_q  <= 1'b0;
      blank_q <= '0;
    end else begin
      mode_q  <= mode_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      presc_q <= presc_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
      tick_q  <= tick_d;
      blank_q <= blank_d;
    end
  end

  assign sec      = sec_q;
  assign min      = min_q;
  assign hour     = hour_q;
  assign mode     = mode_q;
  assign blank    = blank_q;
  assign tick_1hz = tick_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller: reset, run ticking, set, blink, rollover.
module tb_time_set_controller;

  logic       clk_1000hz = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [5:0] sec, min, hour;
  logic [1:0] mode;
  logic [2:0] blank;
  logic       tick_1hz;
  int         chk_cnt = 0;
  int         pass_cnt = 0;

  always #5 clk_1000hz = ~clk_1000hz;

  time_set_controller #(.TICKS_PER_SEC(1000), .BLINK_HALF(500)) dut (
    .clk_1000hz (clk_1000hz),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .sec        (sec),
    .min        (min),
    .hour       (hour),
    .mode       (mode),
    .blank      (blank),
    .tick_1hz   (tick_1hz)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk_1000hz);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    step(2);
    rst = 1'b0;
    step(4);
  endtask

  task automatic press_mode;
    btn_mode = 1'b1; step(4);
    btn_mode = 1'b0; step(4);
  endtask

  task automatic incs(input int n);
    repeat (n) begin
      btn_inc = 1'b1; step(4);
      btn_inc = 1'b0; step(4);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    step(2);
    chk_cnt++;
    if ({hour, min, sec} !== 18'd0) $display("FAIL reset_time: got %0d:%0d:%0d expected 0:0:0", hour, min, sec);
    else pass_cnt++;
    chk_cnt++;
    if ({mode, blank, tick_1hz} !== 6'd0) $display("FAIL reset_ctrl: got mode=%0d blank=%b tick=%b expected 0 000 0", mode, blank, tick_1hz);
    else pass_cnt++;
  endtask

  task automatic test_run_tick;
    rst = 1'b1; step(1); rst = 1'b0;
    step(999);
    chk_cnt++;
    if ({tick_1hz, sec} !== {1'b0, 6'd0}) $display("FAIL pre_tick: got tick=%b sec=%0d expected 0 0", tick_1hz, sec);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if ({tick_1hz, sec} !== {1'b1, 6'd1}) $display("FAIL first_tick: got tick=%b sec=%0d expected 1 1", tick_1hz, sec);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if ({tick_1hz, sec} !== {1'b0, 6'd1}) $display("FAIL tick_pulse_width: got tick=%b sec=%0d expected 0 1", tick_1hz, sec);
    else pass_cnt++;
  endtask

  task automatic test_mode_cycle;
    do_reset();
    btn_mode = 1'b1; step(3);
    chk_cnt++;
    if (mode !== 2'd0) $display("FAIL mode_latency_early: got %0d expected 0", mode);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if ({mode, blank} !== {2'd1, 3'b000}) $display("FAIL mode_set_hour: got mode=%0d blank=%b expected 1 000", mode, blank);
    else pass_cnt++;
    btn_mode = 1'b0; step(500);
    chk_cnt++;
    if (blank !== 3'b100) $display("FAIL blank_hour_sel: got %b expected 100", blank);
    else pass_cnt++;
    btn_mode = 1'b1; step(4);
    chk_cnt++;
    if ({mode, blank} !== {2'd2, 3'b000}) $display("FAIL mode_set_min: got mode=%0d blank=%b expected 2 000", mode, blank);
    else pass_cnt++;
    btn_mode = 1'b0; step(500);
    chk_cnt++;
    if (blank !== 3'b010) $display("FAIL blank_min_sel: got %b expected 010", blank);
    else pass_cnt++;
    btn_mode = 1'b1; step(4);
    chk_cnt++;
    if ({mode, blank} !== {2'd3, 3'b000}) $display("FAIL mode_set_sec: got mode=%0d blank=%b expected 3 000", mode, blank);
    else pass_cnt++;
    btn_mode = 1'b0; step(500);
    chk_cnt++;
    if (blank !== 3'b001) $display("FAIL blank_sec_sel: got %b expected 001", blank);
    else pass_cnt++;
    btn_mode = 1'b1; step(4);
    btn_mode = 1'b0; step(500);
    chk_cnt++;
    if ({mode, blank} !== {2'd0, 3'b000}) $display("FAIL mode_back_run: got mode=%0d blank=%b expected 0 000", mode, blank);
    else pass_cnt++;
  endtask

  task automatic test_set_wrap;
    do_reset();
    press_mode();
    incs(24);
    chk_cnt++;
    if ({hour, min, sec} !== 18'd0) $display("FAIL hour_wrap: got %0d:%0d:%0d expected 0:0:0", hour, min, sec);
    else pass_cnt++;
    press_mode();
    incs(59);
    chk_cnt++;
    if ({hour, min, sec} !== {6'd0, 6'd59, 6'd0}) $display("FAIL min_to_59: got %0d:%0d:%0d expected 0:59:0", hour, min, sec);
    else pass_cnt++;
    incs(1);
    chk_cnt++;
    if ({mode, hour, min, sec} !== {2'd2, 18'd0}) $display("FAIL min_wrap_no_carry: got mode=%0d %0d:%0d:%0d expected 2 0:0:0", mode, hour, min, sec);
    else pass_cnt++;
  endtask

  task automatic test_inc_ignored_run;
    do_reset();
    incs(3);
    chk_cnt++;
    if ({mode, hour, min, sec} !== 20'd0) $display("FAIL inc_in_run: got mode=%0d %0d:%0d:%0d expected 0 0:0:0", mode, hour, min, sec);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous;
    do_reset();
    press_mode();
    incs(5);
    chk_cnt++;
    if ({mode, hour} !== {2'd1, 6'd5}) $display("FAIL preload_hour5: got mode=%0d hour=%0d expected 1 5", mode, hour);
    else pass_cnt++;
    btn_mode = 1'b1; btn_inc = 1'b1; step(4);
    chk_cnt++;
    if ({mode, hour, min} !== {2'd2, 6'd5, 6'd0}) $display("FAIL simul_events: got mode=%0d hour=%0d min=%0d expected 2 5 0", mode, hour, min);
    else pass_cnt++;
    btn_mode = 1'b0; btn_inc = 1'b0; step(4);
  endtask

  task automatic test_blink;
    do_reset();
    btn_mode = 1'b1; step(4); btn_mode = 1'b0;
    step(499);
    chk_cnt++;
    if (blank !== 3'b000) $display("FAIL blink_low_half: got %b expected 000", blank);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if (blank !== 3'b100) $display("FAIL blink_rise: got %b expected 100", blank);
    else pass_cnt++;
    step(499);
    chk_cnt++;
    if (blank !== 3'b100) $display("FAIL blink_high_half: got %b expected 100", blank);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if (blank !== 3'b000) $display("FAIL blink_fall: got %b expected 000", blank);
    else pass_cnt++;
    step(500);
    btn_inc = 1'b1; step(3);
    chk_cnt++;
    if ({blank, hour} !== {3'b100, 6'd0}) $display("FAIL blink_before_inc: got blank=%b hour=%0d expected 100 0", blank, hour);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if ({blank, hour} !== {3'b000, 6'd1}) $display("FAIL blink_clear_on_inc: got blank=%b hour=%0d expected 000 1", blank, hour);
    else pass_cnt++;
    btn_inc = 1'b0; step(4);
  endtask

  task automatic test_rollover;
    do_reset();
    press_mode(); incs(23);
    press_mode(); incs(59);
    press_mode(); incs(59);
    chk_cnt++;
    if ({mode, hour, min, sec} !== {2'd3, 6'd23, 6'd59, 6'd59}) $display("FAIL preload_235959: got mode=%0d %0d:%0d:%0d expected 3 23:59:59", mode, hour, min, sec);
    else pass_cnt++;
    btn_mode = 1'b1; step(4); btn_mode = 1'b0;
    chk_cnt++;
    if ({mode, blank, tick_1hz} !== 6'd0) $display("FAIL rollover_enter_run: got mode=%0d blank=%b tick=%b expected 0 000 0", mode, blank, tick_1hz);
    else pass_cnt++;
    step(999);
    chk_cnt++;
    if ({tick_1hz, sec} !== {1'b0, 6'd59}) $display("FAIL rollover_pre: got tick=%b sec=%0d expected 0 59", tick_1hz, sec);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if ({tick_1hz, hour, min, sec} !== {1'b1, 18'd0}) $display("FAIL rollover_tick: got tick=%b %0d:%0d:%0d expected 1 0:0:0", tick_1hz, hour, min, sec);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_set;
    do_reset();
    press_mode(); incs(12);
    press_mode(); press_mode(); incs(56);
    press_mode(); press_mode(); press_mode(); incs(34);
    chk_cnt++;
    if ({mode, hour, min, sec} !== {2'd2, 6'd12, 6'd34, 6'd56}) $display("FAIL preload_123456: got mode=%0d %0d:%0d:%0d expected 2 12:34:56", mode, hour, min, sec);
    else pass_cnt++;
    btn_inc = 1'b1; step(2);
    rst = 1'b1; step(1);
    chk_cnt++;
    if ({mode, blank, hour, min, sec} !== 23'd0) $display("FAIL reset_mid_set: got mode=%0d blank=%b %0d:%0d:%0d expected 0 000 0:0:0", mode, blank, hour, min, sec);
    else pass_cnt++;
    step(1); rst = 1'b0; step(8);
    btn_mode = 1'b1; step(4); btn_mode = 1'b0; step(10);
    chk_cnt++;
    if ({mode, hour} !== {2'd1, 6'd0}) $display("FAIL held_inc_no_event: got mode=%0d hour=%0d expected 1 0", mode, hour);
    else pass_cnt++;
    btn_inc = 1'b0; step(4);
    btn_inc = 1'b1; step(4); btn_inc = 1'b0;
    chk_cnt++;
    if (hour !== 6'd1) $display("FAIL inc_after_release: got hour=%0d expected 1", hour);
    else pass_cnt++;
    btn_mode = 1'b1; rst = 1'b1; step(2);
    rst = 1'b0; step(10);
    chk_cnt++;
    if (mode !== 2'd0) $display("FAIL held_mode_no_event: got mode=%0d expected 0", mode);
    else pass_cnt++;
    btn_mode = 1'b0; step(4);
  endtask

  initial begin
    test_reset();
    test_run_tick();
    test_mode_cycle();
    test_set_wrap();
    test_inc_ignored_run();
    test_simultaneous();
    test_blink();
    test_rollover();
    test_reset_mid_set();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/time_set_controller.md
TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 1000, meaning clk_1000hz cycles per second.
REQ-002 SHALL have parameter BLINK_HALF, default 500, meaning cycles per blink half-period.
REQ-003 SHALL have port clk_1000hz  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port btn_mode  input  1  raw mode button, asynchronous, active-high.
REQ-006 SHALL have port btn_inc  input  1  raw increment button, asynchronous, active-high.
REQ-007 SHALL have port sec  output  6  current seconds, 0-59, drives the displayer.
REQ-008 SHALL have port min  output  6  current minutes, 0-59.
REQ-009 SHALL have port hour  output  6  current hours, 0-23.
REQ-010 SHALL have port mode  output  2  FSM state: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.
REQ-011 SHALL have port blank  output  3  field blank mask: bit0 sec, bit1 min, bit2 hour.
REQ-012 SHALL have port tick_1hz  output  1  one-cycle pulse at each RUN-mode second increment.

Function
REQ-013 SHALL pass each button through a 2-FF synchronizer, then a rising-edge detector, giving a 1-cycle event; total latency 3 cycles from raw rise to event.
REQ-014 SHALL sequence FSM on mode event: RUN->SET_HOUR->SET_MIN->SET_SEC->RUN; no other transitions.
REQ-015 SHALL, in RUN, count prescaler 0..TICKS_PER_SEC-1; at terminal count wrap to 0, pulse tick_1hz, increment sec.
REQ-016 SHALL carry sec 59->0 into min; min 59->0 into hour; hour 23->0; all carries in the same cycle as the tick.
REQ-017 SHALL, in any SET state, hold prescaler at 0, freeze time, and keep tick_1hz low.
REQ-018 SHALL, on inc event in SET_HOUR/SET_MIN/SET_SEC, increment only the selected field, wrapping 23->0 or 59->0 with no carry into other fields.
REQ-019 SHALL ignore inc events in RUN.
REQ-020 SHALL, when mode and inc events occur in the same cycle, take the mode transition and discard inc.
REQ-021 SHALL restart prescaler from 0 on the SET_SEC->RUN transition; the first tick follows TICKS_PER_SEC cycles later.
REQ-022 SHALL toggle a blink phase every BLINK_HALF cycles in SET states; blink phase and blink counter clear on every mode transition and every accepted inc.
REQ-023 SHALL drive blank bit of the selected field = blink phase in SET states; all other bits 0; blank = 0 in RUN.
REQ-024 SHALL register all outputs; field update is visible one cycle after the causing event.

Reset
REQ-025 SHALL, while rst high at a clock edge, set sec=min=hour=0, mode=RUN, blank=0, tick_1hz=0, prescaler=0, blink state=0, synchronizer/edge flops=0.
REQ-026 SHALL let rst override all events in the same cycle, including mid-SET operation; no edge event is generated from a button held across reset release.

Structure
REQ-027 SHALL place mode encoding and limits (SEC_MAX 59, MIN_MAX 59, HOUR_MAX 23) in shared package clock_pkg.
REQ-028 SHALL implement synchronizer + edge detector as sub-module btn_edge, instantiated twice.

Verification
REQ-029 SHALL cover rollover: preload 23:59:59 via SET, return RUN, wait 1000 cycles -> tick_1hz pulse, time 00:00:00.
REQ-030 SHALL cover set wrap: SET_MIN at min=59, one inc -> min=0, hour unchanged.
REQ-031 SHALL cover mode cycling: 4 mode pulses -> mode 1,2,3,0; blank bit2, bit1, bit0 selected in turn.
REQ-032 SHALL cover simultaneous events: mode and inc rise same cycle in SET_HOUR at hour=5 -> mode=SET_MIN, hour=5.
REQ-033 SHALL cover blink: hold SET_HOUR 1000 cycles -> blank[2] 0 for 500, 1 for 500; inc -> blank[2]=0 next cycle.
REQ-034 SHALL cover reset mid-SET: rst in SET_MIN at 12:34:56 with btn_inc held -> 00:00:00, RUN, no inc event after release.
